store_commit_queue: RTL and testbench

STORE_COMMIT_QUEUE -- requirements
Module: store_commit_queue

---
 rtl/store_commit_queue_pkg.sv | 24 ++
 rtl/store_commit_queue_if.sv | 28 ++
 rtl/store_commit_queue_fwd_match.sv | 34 +++
 rtl/store_commit_queue.sv | 105 ++++++++++
 tb/tb_store_commit_queue.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/store_commit_queue_pkg.sv
// Shared types and defaults for the store commit queue: entry layout, FSM states
// and the word-granular address compare used by load forwarding.
package store_commit_queue_pkg;

    localparam int STQ_DEPTH = 4;
    localparam int STQ_XLEN  = 32;

    typedef struct packed {
        logic [STQ_XLEN-1:0] addr;
        logic [STQ_XLEN-1:0] data;
    } stq_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } stq_state_e;

    // Stores and loads match on the same aligned 32-bit word; byte offset ignored.
    function automatic logic stq_word_match(input logic [STQ_XLEN-1:0] a,
                                            input logic [STQ_XLEN-1:0] b);
        return a[STQ_XLEN-1:2] == b[STQ_XLEN-1:2];
    endfunction

endpackage

// File: rtl/store_commit_queue_if.sv
// Retire, data-memory write and load-lookup signals of the store commit queue.
// The queue itself is the slave; the core/memory side is the master.
interface store_commit_queue_if
    import store_commit_queue_pkg::*;
#(
    parameter int XLEN = STQ_XLEN
);
    logic            ret_store_valid;
    logic [XLEN-1:0] ret_store_addr;
    logic [XLEN-1:0] ret_store_data;
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ack;
    logic [XLEN-1:0] ld_addr;
    logic            fwd_hit;
    logic [XLEN-1:0] fwd_data;

    modport master (
        output ret_store_valid, ret_store_addr, ret_store_data, mem_ack, ld_addr,
        input  mem_req, mem_addr, mem_wdata, fwd_hit, fwd_data
    );

    modport slave (
        input  ret_store_valid, ret_store_addr, ret_store_data, mem_ack, ld_addr,
        output mem_req, mem_addr, mem_wdata, fwd_hit, fwd_data
    );
endinterface

// File: rtl/store_commit_queue_fwd_match.sv
// Store-to-load forwarding lookup, built only with STQ_LOAD_FWD_EN defined.
// Walks occupied entries oldest to youngest so the last match wins.
`ifdef STQ_LOAD_FWD_EN
module stq_fwd_match
    import store_commit_queue_pkg::*;
#(
    parameter int DEPTH = STQ_DEPTH,
    parameter int XLEN  = STQ_XLEN
) (
    input  stq_entry_t                 entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   head,
    input  logic [$clog2(DEPTH):0]     count,
    input  logic [XLEN-1:0]            ld_addr,
    output logic                       hit,
    output logic [XLEN-1:0]            data
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx;

    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (((PTR_W+1)'(i) < count) && stq_word_match(entries[idx].addr, ld_addr)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end
endmodule
`endif

// File: rtl/store_commit_queue.sv
// Post-retire store queue: buffers committed stores and drains them in order to data
// memory. Optional load forwarding is enabled by defining STQ_LOAD_FWD_EN.
module store_commit_queue
    import store_commit_queue_pkg::*;
#(
    parameter int DEPTH = STQ_DEPTH,
    parameter int XLEN  = STQ_XLEN
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    store_commit_queue_if.slave      bus,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int                 PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]     FULL_CNT = (PTR_W+1)'(DEPTH);

    if (XLEN != STQ_XLEN || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_cfg_check
        $error("store_commit_queue: DEPTH must be a power of two >= 2 and XLEN must equal STQ_XLEN");
    end

    stq_entry_t       entries [DEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [PTR_W:0]   count_q, count_d;
    stq_state_e       state_q, state_d;
    logic             push, pop;

    assign o_full  = (count_q == FULL_CNT);
    assign o_empty = (count_q == '0);
    assign o_count = count_q;

    // Full is judged on the registered count, so a pop never frees room in the same cycle.
    assign push = bus.ret_store_valid && !o_full;
    assign pop  = (state_q == REQ) && bus.mem_ack;

    always_comb begin
        count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= IDLE;
        end else begin
            count_q <= count_d;
            state_q <= state_d;
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
        end
    end

    // NOTE: payload storage has no reset; count and pointers alone define which entries are live.
    always_ff @(posedge i_clk) begin
        if (push) entries[tail_q] <= '{addr: bus.ret_store_addr, data: bus.ret_store_data};
    end

    // NOTE: defaults first so no path through the case leaves an output unassigned (no latch).
    always_comb begin
        state_d       = state_q;
        bus.mem_req   = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        unique case (state_q)
            IDLE: begin
                if (!o_empty) state_d = REQ;
            end
            REQ: begin
                bus.mem_req   = 1'b1;
                bus.mem_addr  = entries[head_q].addr;
                bus.mem_wdata = entries[head_q].data;
                if (pop && count_d == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef STQ_LOAD_FWD_EN
    stq_fwd_match #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN)
    ) u_fwd_match (
        .entries (entries),
        .head    (head_q),
        .count   (count_q),
        .ld_addr (bus.ld_addr),
        .hit     (bus.fwd_hit),
        .data    (bus.fwd_data)
    );
`else
    logic unused_ld_addr;
    assign unused_ld_addr = ^bus.ld_addr;
    assign bus.fwd_hit    = 1'b0;
    assign bus.fwd_data   = '0;
`endif

    // A retiring store arriving while full is lost; flag it in simulation.
    stq_drop_a: assert property (@(posedge i_clk) disable iff (!i_rst_n)
                                 !(bus.ret_store_valid && o_full))
        else $warning("store_commit_queue: retiring store dropped, queue full");

endmodule

// File: tb/tb_store_commit_queue.sv
// Scoreboard bench for store_commit_queue: accepted stores are queued as expected
// commits and compared against every mem_req/mem_ack handshake.
module tb_store_commit_queue;
    import store_commit_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic       clk;
    logic       rst_n;
    logic       full, empty;
    logic [2:0] count;

    store_commit_queue_if #(.XLEN(XLEN)) dif ();

    store_commit_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (dif.slave),
        .o_full  (full),
        .o_empty (empty),
        .o_count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    int         model_cnt = 0;
    stq_entry_t sb [$];
    int         pop_cyc [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called just after a negedge with inputs set: score this cycle, then advance one clock.
    task automatic tick();
        stq_entry_t exp;
        logic       do_pop;
        logic       do_push;
        do_pop  = dif.mem_req && dif.mem_ack;
        do_push = dif.ret_store_valid && (model_cnt < DEPTH);
        if (do_pop) begin
            pop_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                check("pop_unexpected", 32'd1, 32'd0);
            end else begin
                exp = sb.pop_front();
                check("commit_addr", dif.mem_addr, exp.addr);
                check("commit_data", dif.mem_wdata, exp.data);
            end
        end
        if (do_push) sb.push_back('{addr: dif.ret_store_addr, data: dif.ret_store_data});
        model_cnt = model_cnt + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic push_store(input logic [31:0] a, input logic [31:0] d);
        dif.ret_store_valid = 1'b1;
        dif.ret_store_addr  = a;
        dif.ret_store_data  = d;
        tick();
        dif.ret_store_valid = 1'b0;
    endtask

    task automatic drain();
        dif.ret_store_valid = 1'b0;
        dif.mem_ack         = 1'b1;
        for (int i = 0; i < 40 && model_cnt != 0; i++) tick();
        check("drain_done", 32'(model_cnt), 32'd0);
        dif.mem_ack = 1'b0;
        tick();
        check("drain_empty", 32'(empty), 32'd1);
        check("drain_no_req", 32'(dif.mem_req), 32'd0);
        check("drain_sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n               = 1'b0;
        dif.ret_store_valid = 1'b0;
        dif.ret_store_addr  = '0;
        dif.ret_store_data  = '0;
        dif.mem_ack         = 1'b0;
        dif.ld_addr         = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_mem_req", 32'(dif.mem_req), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_fwd_hit", 32'(dif.fwd_hit), 32'd0);
        check("rst_fwd_data", dif.fwd_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single store: one IDLE cycle after becoming non-empty, then a stable request
        push_store(32'h100, 32'hDEAD);
        check("lat_idle_req", 32'(dif.mem_req), 32'd0);
        check("lat_count", 32'(count), 32'd1);
        tick();
        for (int i = 0; i < 10; i++) begin
            check("hold_req", 32'(dif.mem_req), 32'd1);
            check("hold_addr", dif.mem_addr, 32'h100);
            check("hold_data", dif.mem_wdata, 32'hDEAD);
            tick();
        end
        drain();

        // Ack while idle is ignored
        dif.mem_ack = 1'b1;
        tick();
        dif.mem_ack = 1'b0;
        check("idle_ack_count", 32'(count), 32'd0);
        check("idle_ack_req", 32'(dif.mem_req), 32'd0);

        // Fill, drop a fifth store, ack one
        for (int i = 0; i < 4; i++) push_store(32'h300 + 32'(i * 4), 32'hA0 + 32'(i));
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd4);
        push_store(32'h999, 32'hBAD);
        check("drop_count", 32'(count), 32'd4);
        dif.mem_ack = 1'b1;
        tick();
        dif.mem_ack = 1'b0;
        check("ack1_full", 32'(full), 32'd0);
        check("ack1_count", 32'(count), 32'd3);
        drain();

        // Three stores with ack held: back-to-back commits
        pop_cyc.delete();
        dif.mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) push_store(32'h400 + 32'(i * 4), 32'hC0 + 32'(i));
        drain();
        check("b2b_pops", 32'(pop_cyc.size()), 32'd3);
        if (pop_cyc.size() == 3) check("b2b_span", 32'(pop_cyc[2] - pop_cyc[0]), 32'd2);

        // Full queue with simultaneous push and ack: pop only
        for (int i = 0; i < 4; i++) push_store(32'h500 + 32'(i * 4), 32'hD0 + 32'(i));
        dif.mem_ack = 1'b1;
        push_store(32'h5FC, 32'hEEE);
        dif.mem_ack = 1'b0;
        check("fullpp_count", 32'(count), 32'd3);
        check("fullpp_full", 32'(full), 32'd0);
        drain();

        // Eight pushes with ack held: pointers wrap, order preserved
        dif.mem_ack = 1'b1;
        for (int i = 0; i < 8; i++) push_store(32'h1000 + 32'(i * 4), $urandom);
        drain();

        // Load forwarding
        push_store(32'h200, 32'h11);
        push_store(32'h200, 32'h22);
        dif.ld_addr = 32'h202;
        #1;
`ifdef STQ_LOAD_FWD_EN
        check("fwd_hit_same_word", 32'(dif.fwd_hit), 32'd1);
        check("fwd_data_youngest", dif.fwd_data, 32'h22);
        dif.ld_addr = 32'h204;
        #1;
        check("fwd_miss_next_word", 32'(dif.fwd_hit), 32'd0);
`else
        check("fwd_off_hit", 32'(dif.fwd_hit), 32'd0);
        check("fwd_off_data", dif.fwd_data, 32'd0);
`endif
        dif.ld_addr = '0;
        drain();

        // Reset mid-request drops mem_req immediately and discards entries
        push_store(32'h600, 32'h61);
        push_store(32'h604, 32'h62);
        check("mid_req_before_rst", 32'(dif.mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_drops_req", 32'(dif.mem_req), 32'd0);
        check("rst_clears_count", 32'(count), 32'd0);
        sb.delete();
        model_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_no_req", 32'(dif.mem_req), 32'd0);
        end
        check("post_rst_empty", 32'(empty), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
